// File: rtl/fp64_pkg.sv
// Shared constants and types for the binary64 multiplier datapath.
package fp64_pkg;

   localparam int unsigned BIAS   = 1023;
   localparam int unsigned EXP_W  = 11;
   localparam int unsigned FRAC_W = 52;
   localparam int unsigned MANT_W = 53;
   localparam int unsigned PROD_W = 106;
   localparam logic [EXP_W-1:0] EXP_MAX = 11'd2047;

   typedef logic [1:0] fp_class_t;
   localparam fp_class_t CLS_NORMAL = 2'b00;
   localparam fp_class_t CLS_ZERO   = 2'b01;
   localparam fp_class_t CLS_INF    = 2'b10;
   localparam fp_class_t CLS_NAN    = 2'b11;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_MUL  = 2'd1;
   localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/fp64_unpack.sv
// Combinational binary64 field extraction, denormal flush and special-value detection.
module fp64_unpack
   import fp64_pkg::*;
(
   input  logic [63:0]       op,
   output logic              sign,
   output logic [EXP_W-1:0]  exp,
   output logic [MANT_W-1:0] mant,
   output logic              is_nan,
   output logic              is_inf,
   output logic              is_zero
);

   logic [FRAC_W-1:0] frac;

   assign sign    = op[63];
   assign exp     = op[62:52];
   assign frac    = op[FRAC_W-1:0];
   // is_inf covers every e=2047 encoding; callers test NaN first
   assign is_inf  = (exp == EXP_MAX);
   assign is_nan  = is_inf && (frac != '0);
   assign is_zero = (exp == '0);
   assign mant    = is_zero ? '0 : {1'b1, frac};

endmodule

// File: rtl/fp64_mant_mul_seq.sv
// Sequential binary64 multiplier front end: classify, exponent sum and a
// chunked iterative significand product feeding the normalizer.
module fp64_mant_mul_seq
   import fp64_pkg::*;
#(
   parameter int unsigned CHUNK = 14
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [63:0]       in_a,
   input  logic [63:0]       in_b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PROD_W-1:0] out_prod,
   output logic [EXP_W-1:0]  out_exp,
   output logic              out_sign,
   output logic [1:0]        out_class,
   output logic              out_ovf,
   output logic              out_unf
);

   localparam int unsigned NCHUNK = (MANT_W + CHUNK - 1) / CHUNK;
   localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int unsigned PAD_W  = NCHUNK * CHUNK;
   localparam int unsigned PART_W = MANT_W + CHUNK;

   logic              sign_a, sign_b;
   logic [EXP_W-1:0]  exp_a, exp_b;
   logic [MANT_W-1:0] mant_a, mant_b;
   logic              nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;

   fp64_unpack u_unpack_a (
      .op      (in_a),
      .sign    (sign_a),
      .exp     (exp_a),
      .mant    (mant_a),
      .is_nan  (nan_a),
      .is_inf  (inf_a),
      .is_zero (zero_a)
   );

   fp64_unpack u_unpack_b (
      .op      (in_b),
      .sign    (sign_b),
      .exp     (exp_b),
      .mant    (mant_b),
      .is_nan  (nan_b),
      .is_inf  (inf_b),
      .is_zero (zero_b)
   );

   fp_class_t         cls_c;
   logic              sign_c;
   logic signed [12:0] ebias;
   logic              ovf_c, unf_c;
   logic [EXP_W-1:0]  exp_c;

   always_comb begin
      cls_c = CLS_NORMAL;
      if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a)) begin
         cls_c = CLS_NAN;
      end else if (inf_a || inf_b) begin
         cls_c = CLS_INF;
      end else if (zero_a || zero_b) begin
         cls_c = CLS_ZERO;
      end
   end

   assign sign_c = (cls_c == CLS_NAN) ? 1'b0 : (sign_a ^ sign_b);
   assign ebias  = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - $signed(13'(BIAS));
   assign ovf_c  = (cls_c == CLS_NORMAL) && (ebias >= 13'sd2047);
   assign unf_c  = (cls_c == CLS_NORMAL) && (ebias <= 13'sd0);

   always_comb begin
      exp_c = '0;
      unique case (cls_c)
         CLS_NORMAL: begin
            if (ovf_c)      exp_c = EXP_MAX;
            else if (unf_c) exp_c = '0;
            else            exp_c = ebias[EXP_W-1:0];
         end
         CLS_ZERO: exp_c = '0;
         default:  exp_c = EXP_MAX;
      endcase
   end

   state_t              state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [PROD_W-1:0]   acc_q;
   logic [MANT_W-1:0]   ma_q;
   logic [PAD_W-1:0]    mb_q;
   logic                sign_q, ovf_q, unf_q;
   fp_class_t           cls_q;
   logic [EXP_W-1:0]    exp_q;

   logic [CHUNK-1:0]    mb_chunk;
   logic [PART_W-1:0]   partial;
   logic [PROD_W-1:0]   addend;

   // Only registered operands feed the iteration, so input changes after accept are harmless
   assign mb_chunk = mb_q[cnt_q*CHUNK +: CHUNK];
   assign partial  = PART_W'(ma_q) * PART_W'(mb_chunk);
   assign addend   = PROD_W'(partial) << (cnt_q * CHUNK);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         ma_q    <= '0;
         mb_q    <= '0;
         sign_q  <= 1'b0;
         cls_q   <= CLS_NORMAL;
         exp_q   <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  ma_q    <= mant_a;
                  mb_q    <= PAD_W'(mant_b);
                  sign_q  <= sign_c;
                  cls_q   <= cls_c;
                  exp_q   <= exp_c;
                  ovf_q   <= ovf_c;
                  unf_q   <= unf_c;
                  acc_q   <= '0;
                  cnt_q   <= '0;
                  state_q <= ST_MUL;
               end
            end
            ST_MUL: begin
               acc_q <= acc_q + addend;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CNT_W'(NCHUNK - 1)) begin
                  state_q <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign out_prod  = (cls_q == CLS_NORMAL) ? acc_q : '0;
   assign out_exp   = exp_q;
   assign out_sign  = sign_q;
   assign out_class = cls_q;
   assign out_ovf   = ovf_q;
   assign out_unf   = unf_q;

endmodule

// File: tb/tb_fp64_mant_mul_seq.sv
// Directed self-checking bench for fp64_mant_mul_seq.
module tb_fp64_mant_mul_seq;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [63:0]  in_a;
   logic [63:0]  in_b;
   logic         out_valid;
   logic         out_ready;
   logic [105:0] out_prod;
   logic [10:0]  out_exp;
   logic         out_sign;
   logic [1:0]   out_class;
   logic         out_ovf;
   logic         out_unf;

   int checks = 0;
   int errors = 0;

   fp64_mant_mul_seq #(.CHUNK(14)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_prod  (out_prod),
      .out_exp   (out_exp),
      .out_sign  (out_sign),
      .out_class (out_class),
      .out_ovf   (out_ovf),
      .out_unf   (out_unf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Launch one operation and wait (bounded) for out_valid; lat counts edges after accept
   task automatic launch(input logic [63:0] a, input logic [63:0] b, output int lat);
      @(negedge clk);
      chk("in_ready_before_accept", 128'(in_ready), 128'(1'b1));
      in_a = a;
      in_b = b;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      in_a = 64'hFFFF_FFFF_FFFF_FFFF;
      in_b = 64'hFFFF_FFFF_FFFF_FFFF;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic payload(input string tag, input logic [105:0] prod, input logic [10:0] exp,
                          input logic sign, input logic [1:0] cls, input logic ovf,
                          input logic unf);
      chk({tag, "_valid"}, 128'(out_valid), 128'(1'b1));
      chk({tag, "_prod"},  128'(out_prod),  128'(prod));
      chk({tag, "_exp"},   128'(out_exp),   128'(exp));
      chk({tag, "_sign"},  128'(out_sign),  128'(sign));
      chk({tag, "_class"}, 128'(out_class), 128'(cls));
      chk({tag, "_ovf"},   128'(out_ovf),   128'(ovf));
      chk({tag, "_unf"},   128'(out_unf),   128'(unf));
   endtask

   task automatic release_out(input string tag);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_valid_falls"}, 128'(out_valid), 128'(1'b0));
      chk({tag, "_ready_rises"}, 128'(in_ready),  128'(1'b1));
   endtask

   initial begin
      int lat;
      int seen;
      logic [105:0] ones53;
      logic [105:0] ones_sq;

      ones53  = {53'd0, {53{1'b1}}};
      ones_sq = ones53 * ones53;

      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_a      = '0;
      in_b      = '0;
      rst_n     = 1'b1;
      #1 rst_n  = 1'b0;
      #1;
      chk("reset_in_ready",  128'(in_ready),  128'(1'b1));
      chk("reset_out_valid", 128'(out_valid), 128'(1'b0));
      chk("reset_prod",      128'(out_prod),  128'(0));
      chk("reset_exp",       128'(out_exp),   128'(0));
      @(negedge clk);
      rst_n = 1'b1;

      // 1.0 x 1.0, with a held output stage
      launch(64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000, lat);
      chk("one_latency", 128'(lat), 128'(4));
      payload("one", 106'd1 << 104, 11'd1023, 1'b0, 2'b00, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_a = 64'h4000_0000_0000_0000;
         in_b = 64'h4000_0000_0000_0000;
         @(negedge clk);
         in_valid = 1'b0;
         chk("hold_in_ready", 128'(in_ready), 128'(1'b0));
         payload("hold", 106'd1 << 104, 11'd1023, 1'b0, 2'b00, 1'b0, 1'b0);
      end
      release_out("one");

      launch(64'h3FF8_0000_0000_0000, 64'h3FF8_0000_0000_0000, lat);
      chk("onehalf_latency", 128'(lat), 128'(4));
      payload("onehalf", 106'd9 << 102, 11'd1023, 1'b0, 2'b00, 1'b0, 1'b0);
      release_out("onehalf");

      launch(64'hC000_0000_0000_0000, 64'h4008_0000_0000_0000, lat);
      payload("m2x3", 106'd3 << 103, 11'd1025, 1'b1, 2'b00, 1'b0, 1'b0);
      release_out("m2x3");

      launch(64'h3FFF_FFFF_FFFF_FFFF, 64'h3FFF_FFFF_FFFF_FFFF, lat);
      payload("allones", ones_sq, 11'd1023, 1'b0, 2'b00, 1'b0, 1'b0);
      release_out("allones");

      launch(64'h7FF0_0000_0000_0000, 64'h0000_0000_0000_0000, lat);
      chk("infzero_latency", 128'(lat), 128'(4));
      payload("infzero", 106'd0, 11'd2047, 1'b0, 2'b11, 1'b0, 1'b0);
      release_out("infzero");

      launch(64'h0000_0000_0000_0001, 64'h3FF0_0000_0000_0000, lat);
      payload("denorm", 106'd0, 11'd0, 1'b0, 2'b01, 1'b0, 1'b0);
      release_out("denorm");

      launch(64'h7FE0_0000_0000_0000, 64'h7FE0_0000_0000_0000, lat);
      payload("ovf", 106'd1 << 104, 11'd2047, 1'b0, 2'b00, 1'b1, 1'b0);
      release_out("ovf");

      // e=1 squared: ebias = 1+1-1023 = -1021
      launch(64'h0010_0000_0000_0000, 64'h0010_0000_0000_0000, lat);
      payload("unf", 106'd1 << 104, 11'd0, 1'b0, 2'b00, 1'b0, 1'b1);
      release_out("unf");

      // Reset during the 2nd MUL cycle aborts the operation
      @(negedge clk);
      in_a = 64'h3FFF_FFFF_FFFF_FFFF;
      in_b = 64'h3FFF_FFFF_FFFF_FFFF;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      chk("abort_pre_prod_nonzero", 128'(out_prod != '0), 128'(1'b1));
      rst_n = 1'b0;
      #1;
      chk("abort_valid",    128'(out_valid), 128'(1'b0));
      chk("abort_prod",     128'(out_prod),  128'(0));
      chk("abort_exp",      128'(out_exp),   128'(0));
      chk("abort_in_ready", 128'(in_ready),  128'(1'b1));
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("abort_no_valid", 128'(seen), 128'(0));

      launch(64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000, lat);
      chk("recover_latency", 128'(lat), 128'(4));
      payload("recover", 106'd1 << 104, 11'd1023, 1'b0, 2'b00, 1'b0, 1'b0);
      release_out("recover");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fp64_mant_mul_seq.md
# fp64_mant_mul_seq

Sequential front end of the double-precision multiplier datapath. Accepts two IEEE-754 binary64 operands over a valid/ready handshake, unpacks and classifies them, computes sign and biased exponent sum, and forms the full 106-bit significand product iteratively over several cycles. Its outputs (`out_prod`, `out_exp`) feed the normalizer stage directly.

## Interface
- `CHUNK`, 14: multiplier-operand slice width per iteration. Derived localparam `NCHUNK = ceil(53/CHUNK)` (4 at default).
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  block can accept operands.
- `in_a`  in  64  binary64 operand A.
- `in_b`  in  64  binary64 operand B.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts result.
- `out_prod`  out  106  significand product, binary point between bits 104 and 103.
- `out_exp`  out  11  biased exponent before normalization.
- `out_sign`  out  1  result sign.
- `out_class`  out  2  00 normal, 01 zero, 10 inf, 11 NaN.
- `out_ovf`  out  1  exponent overflow before normalization.
- `out_unf`  out  1  exponent underflow before normalization.

## Operation
- Unpack: sign s, exponent e (11b), fraction f (52b). Significand m = {1,f} when e≠0. Denormals flush to zero.
- Classify, highest priority first:
  - NaN: either operand NaN (e=2047, f≠0), or inf×zero.
  - inf: either operand has e=2047.
  - zero: either operand has e=0.
  - otherwise normal.
- Sign: sa^sb, except NaN, which forces sign 0.
- Exponent: ebias = ea+eb−1023, computed as a 13-bit signed value.
  - `out_ovf` = (ebias ≥ 2047), normal class only.
  - `out_unf` = (ebias ≤ 0), normal class only.
- `out_exp`:
  - ebias[10:0] for a normal result with no flag.
  - 2047 on ovf; 0 on unf.
  - 0 for zero class; 2047 for inf and NaN classes.
- Multiply: B significand is zero-padded to NCHUNK*CHUNK bits. Iteration i adds (ma × mb[i*CHUNK +: CHUNK]) << (i*CHUNK) into a 106-bit accumulator, which is cleared on accept.
- `out_prod` is the accumulator for normal class and 0 for every other class. The iteration count is always NCHUNK, independent of class.
- FSM:
  - IDLE: `in_ready`=1. On `in_valid`, latch operands and derived fields, set cnt=0, go to MUL.
  - MUL: one accumulate per cycle, cnt++. After the accumulate with cnt=NCHUNK−1, go to DONE.
  - DONE: `out_valid`=1. When `out_ready`=1, go to IDLE.
- `in_ready` is asserted only in IDLE; there is no overlap between operations. `in_valid` in MUL or DONE is ignored.

## Timing
- Reset (async, immediate): state IDLE, cnt 0, accumulator 0. All outputs 0 except `in_ready`, which is 1 once in IDLE.
- Accept edge E0: `in_valid`&`in_ready` sampled high.
- Accumulates occur on edges E1..E_NCHUNK. `out_valid` rises after edge E_NCHUNK, which is 4 cycles after E0 at default CHUNK.
- While `out_valid`=1 and `out_ready`=0, all out_* signals are held stable and `out_valid` stays high.
- Transfer edge: `out_valid`&`out_ready`. The next edge returns to IDLE, `out_valid` falls, and `in_ready` rises in the same cycle.
- Minimum initiation interval: NCHUNK+2 cycles (6 at default) with `out_ready` tied high.
- Reset mid-MUL or mid-DONE aborts the operation. No `out_valid` is produced for the aborted operands.
- Sequential reads use only registered operands, so input changes after E0 have no effect.

## Structure
- Shared package `fp64_pkg` holds:
  - Constants: BIAS=1023, EXP_W=11, FRAC_W=52, MANT_W=53, PROD_W=106, EXP_MAX=2047.
  - The 2-bit class typedef and its encodings.
  - FSM state typedef.
- Sub-module `fp64_unpack` is combinational: field extraction, denormal flush, classification. Instantiate it once per operand.
- FSM, counter, accumulator and exponent logic stay in the top module.

## Test plan
- 1.0×1.0 (both 0x3FF0000000000000):
  - `out_prod` = 1<<104, `out_exp`=1023, sign 0, class 00, flags 0.
  - `out_valid` 4 cycles after accept.
- 1.5×1.5 (0x3FF8000000000000): `out_prod` = 9<<102 (bits 105 and 102 set), `out_exp`=1023.
- −2×3 (0xC000000000000000, 0x4008000000000000): sign 1, `out_exp`=1025, `out_prod` = 3<<103.
- Specials:
  - +inf×+0 (0x7FF0000000000000, 0): class 11, sign 0, `out_exp`=2047, `out_prod`=0.
  - Denormal 0x0000000000000001 × 1.0: class 01, `out_exp`=0.
- Overflow: 0x7FE0000000000000 squared gives ebias 3069, so `out_ovf`=1 and `out_exp`=2047.
- Handshake and reset:
  - Hold `out_ready`=0 for 3 cycles after `out_valid`: payload stable, `in_ready`=0, `in_valid` pulses ignored. Release: IDLE on the next edge.
  - Assert `rst_n`=0 during the 2nd MUL cycle: outputs clear immediately and no `out_valid` appears.
